// File: rtl/auth_responder_param_if.sv
// Transport + answer-engine bus of the authentication responder.
// The responder uses the slave view; transport/engine models use the master view.
interface auth_responder_param_if #(
    parameter int MSG_LEN = 512
);
    logic                   resp_req_in;
    logic [MSG_LEN-1:0]     auth_msg_resp_in;
    logic                   Ack_in;
    logic                   resp_req_out;
    logic [MSG_LEN-1:0]     auth_msg_resp_out;
    logic                   eng_req;
    logic [1:0]             eng_type;
    logic [7:0]             eng_param1;
    logic [7:0]             eng_param2;
    logic                   eng_ack;
    logic [31:0]            eng_header;
    logic [MSG_LEN-33:0]    eng_payload;
    logic                   busy;

    modport slave (
        input  resp_req_in, auth_msg_resp_in, Ack_in, eng_ack, eng_header, eng_payload,
        output resp_req_out, auth_msg_resp_out, eng_req, eng_type, eng_param1, eng_param2, busy
    );

    modport master (
        output resp_req_in, auth_msg_resp_in, Ack_in, eng_ack, eng_header, eng_payload,
        input  resp_req_out, auth_msg_resp_out, eng_req, eng_type, eng_param1, eng_param2, busy
    );
endinterface

// File: rtl/auth_responder_param.sv
// Authentication responder: decode request header, dispatch to answer engine or build ERROR.
// Optional RESP_STATS_EN adds saturating request/error counters.
module auth_responder_param #(
    parameter int MSG_LEN        = 512,
    parameter int PROTO_VER      = 1,
    parameter int NUM_SLOTS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    auth_responder_param_if.slave bus
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]           stat_req_cnt,
    output logic [15:0]           stat_err_cnt
`endif
);
    localparam int PL = MSG_LEN - 32;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DECODE, ENGINE, SEND} state_t;

    state_t             state_q, state_d;
    logic [31:0]        hdr_q, hdr_d;
    logic               req_prev_q, req_prev_d;
    logic               busy_pend_q, busy_pend_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               resp_q, resp_d;
    logic [MSG_LEN-1:0] out_q, out_d;
    logic               eng_req_q, eng_req_d;
    logic [1:0]         eng_type_q, eng_type_d;
    logic [7:0]         eng_p1_q, eng_p1_d;
    logic [7:0]         eng_p2_q, eng_p2_d;
`ifdef RESP_STATS_EN
    logic [15:0]        req_cnt_q, req_cnt_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
`endif

    logic [7:0] ver, mtype, p1, p2;
    logic       type_ok, slot_bad, busy_set;
    logic       unused_payload;

    assign {ver, mtype, p1, p2} = hdr_q;
    assign type_ok  = (mtype == 8'h81) || (mtype == 8'h82) || (mtype == 8'h83);
    assign slot_bad = (mtype == 8'h82) && ({1'b0, p1} >= 9'(NUM_SLOTS));
    assign busy_set = (state_q != IDLE) && bus.resp_req_in && !req_prev_q;
    // Request payload is not needed: every supported request is fully described by its header.
    assign unused_payload = ^bus.auth_msg_resp_in[PL-1:0];

    function automatic logic [MSG_LEN-1:0] err_msg(input logic [7:0] code);
        return {8'(PROTO_VER), 8'h7F, code, 8'h00, {PL{1'b0}}};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        req_prev_d  = bus.resp_req_in;
        busy_pend_d = busy_pend_q | busy_set;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        out_d       = out_q;
        eng_req_d   = eng_req_q;
        eng_type_d  = eng_type_q;
        eng_p1_d    = eng_p1_q;
        eng_p2_d    = eng_p2_q;
`ifdef RESP_STATS_EN
        req_cnt_d   = req_cnt_q;
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.resp_req_in) begin
                    hdr_d   = bus.auth_msg_resp_in[MSG_LEN-1 -: 32];
                    state_d = DECODE;
`ifdef RESP_STATS_EN
                    req_cnt_d = sat_inc(req_cnt_q);
`endif
                end
            end
            DECODE: begin
                if (ver != 8'(PROTO_VER) || !type_ok || slot_bad) begin
                    out_d   = err_msg((ver != 8'(PROTO_VER)) ? 8'h02 : 8'h01);
                    resp_d  = 1'b1;
                    state_d = SEND;
`ifdef RESP_STATS_EN
                    err_cnt_d = sat_inc(err_cnt_q);
`endif
                end else begin
                    eng_type_d = mtype[1:0];
                    eng_p1_d   = p1;
                    eng_p2_d   = p2;
                    eng_req_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ENGINE;
                end
            end
            ENGINE: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.eng_ack) begin
                    eng_req_d = 1'b0;
                    out_d     = {bus.eng_header, bus.eng_payload};
                    resp_d    = 1'b1;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                        eng_req_d = 1'b0;
                        out_d     = err_msg(8'h04);
                        resp_d    = 1'b1;
                        state_d   = SEND;
`ifdef RESP_STATS_EN
                        err_cnt_d = sat_inc(err_cnt_q);
`endif
                    end
                end
            end
            SEND: begin
                // resp_q low in SEND only after a consumed response with a Busy owed.
                if (!resp_q) begin
                    out_d  = err_msg(8'h03);
                    resp_d = 1'b1;
`ifdef RESP_STATS_EN
                    err_cnt_d = sat_inc(err_cnt_q);
`endif
                end else if (bus.Ack_in) begin
                    resp_d = 1'b0;
                    out_d  = '0;
                    if (busy_pend_q || busy_set) busy_pend_d = 1'b0;
                    else                         state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            req_prev_q  <= 1'b0;
            busy_pend_q <= 1'b0;
            cnt_q       <= '0;
            resp_q      <= 1'b0;
            out_q       <= '0;
            eng_req_q   <= 1'b0;
            eng_type_q  <= '0;
            eng_p1_q    <= '0;
            eng_p2_q    <= '0;
`ifdef RESP_STATS_EN
            req_cnt_q   <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            req_prev_q  <= req_prev_d;
            busy_pend_q <= busy_pend_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            out_q       <= out_d;
            eng_req_q   <= eng_req_d;
            eng_type_q  <= eng_type_d;
            eng_p1_q    <= eng_p1_d;
            eng_p2_q    <= eng_p2_d;
`ifdef RESP_STATS_EN
            req_cnt_q   <= req_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign bus.resp_req_out      = resp_q;
    assign bus.auth_msg_resp_out = out_q;
    assign bus.eng_req           = eng_req_q;
    assign bus.eng_type          = eng_type_q;
    assign bus.eng_param1        = eng_p1_q;
    assign bus.eng_param2        = eng_p2_q;
    assign bus.busy              = (state_q != IDLE);
`ifdef RESP_STATS_EN
    assign stat_req_cnt          = req_cnt_q;
    assign stat_err_cnt          = err_cnt_q;
`endif
endmodule

// File: tb/tb_auth_responder_param.sv
// Randomised + directed bench for auth_responder_param against a transaction-level model.
module tb_auth_responder_param;
    localparam int ML = 128;
    localparam int PL = ML - 32;
    localparam int T  = 16;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    auth_responder_param_if #(.MSG_LEN(ML)) bus();
`ifdef RESP_STATS_EN
    logic [15:0] stat_req_cnt, stat_err_cnt;
`endif

    auth_responder_param #(.MSG_LEN(ML), .PROTO_VER(1), .NUM_SLOTS(NS), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
`ifdef RESP_STATS_EN
        , .stat_req_cnt(stat_req_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---- model state ----
    logic [ML-1:0] exp_q[$];
    logic [ML-1:0] last_resp = '0;
    bit            mon_en = 0, ack_en = 1, resp_seen = 0;
    int            eng_delay_cfg = -1;
    logic [31:0]   eng_hdr_cfg = '0;
    logic [PL-1:0] eng_pay_cfg = '0;
    logic [1:0]    exp_eng_type = '0;
    logic [7:0]    exp_p1 = '0, exp_p2 = '0, last_eng_p1 = '0;
    logic [1:0]    last_eng_type = '0;
    int            eng_rise_cyc = 0, eng_high = 0, resp_rise_cyc = 0, ack_cyc = 0;
    int            acc_m = 0, err_m = 0;

    function automatic logic [ML-1:0] rand_bits();
        logic [ML-1:0] v;
        for (int i = 0; i < ML; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ML-1:0] err_resp(input logic [7:0] code);
        return {8'h01, 8'h7F, code, 8'h00, {PL{1'b0}}};
    endfunction

    // Error code a header earns, 0 when it should go to the engine.
    function automatic logic [7:0] decode_err(input logic [31:0] h);
        if (h[31:24] != 8'h01) return 8'h02;
        if (!(h[23:16] inside {8'h81, 8'h82, 8'h83})) return 8'h01;
        if (h[23:16] == 8'h82 && int'(h[15:8]) >= NS) return 8'h01;
        return 8'h00;
    endfunction

    // ---- engine model: acks eng_delay_cfg cycles after eng_req rises, noise otherwise ----
    initial begin
        int ek;
        ek = 0;
        bus.eng_ack = 0; bus.eng_header = '0; bus.eng_payload = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.eng_req) begin
                bus.eng_ack = (ek == eng_delay_cfg);
                if (ek == eng_delay_cfg) begin
                    bus.eng_header = eng_hdr_cfg; bus.eng_payload = eng_pay_cfg; ack_cyc = cyc;
                end
                ek++;
            end else begin
                logic [ML-1:0] r;
                ek = 0;
                r = rand_bits();
                bus.eng_ack = ($urandom % 4 == 0);
                bus.eng_header = r[ML-1 -: 32]; bus.eng_payload = r[PL-1:0];
            end
        end
    end

    // ---- transport ack model (random, including while no response is pending) ----
    initial begin
        bus.Ack_in = 0;
        forever begin
            @(posedge clk); #1;
            bus.Ack_in = ack_en && ($urandom % 3 == 0);
        end
    end

    // ---- compare process ----
    initial begin
        bit eprev, rprev;
        eprev = 0; rprev = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.resp_req_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", bus.resp_req_out, 1'b0);
                    end else begin
                        chk("resp_data", bus.auth_msg_resp_out, exp_q[0]);
                        if (bus.Ack_in) begin
                            last_resp = bus.auth_msg_resp_out;
                            void'(exp_q.pop_front());
                        end
                    end
                    if (!rprev && !resp_seen) begin resp_rise_cyc = cyc; resp_seen = 1; end
                end else begin
                    chk("idle_data", bus.auth_msg_resp_out, '0);
                end
                if (bus.eng_req) begin
                    if (!eprev) begin eng_rise_cyc = cyc; eng_high = 0; end
                    eng_high++;
                    chk("eng_type", bus.eng_type, exp_eng_type);
                    chk("eng_param1", bus.eng_param1, exp_p1);
                    chk("eng_param2", bus.eng_param2, exp_p2);
                    last_eng_type = bus.eng_type; last_eng_p1 = bus.eng_param1;
                end
                eprev = bus.eng_req; rprev = bus.resp_req_out;
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) break;
        end
        if (i == 300) begin
            chk("idle_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_req(input logic [31:0] h, input int dly, input bit bpulse, input bit hold,
                          input logic [31:0] ehdr);
        logic [7:0]    code;
        logic [ML-1:0] r;
        int            t0;
        code = decode_err(h);
        eng_delay_cfg = (code == 0) ? dly : -1;
        eng_hdr_cfg = ehdr;
        r = rand_bits(); eng_pay_cfg = r[PL-1:0];
        exp_p1 = h[15:8]; exp_p2 = h[7:0];
        case (h[23:16])
            8'h81:   exp_eng_type = 2'd1;
            8'h82:   exp_eng_type = 2'd2;
            default: exp_eng_type = 2'd3;
        endcase
        if (code != 0)                 begin exp_q.push_back(err_resp(code)); err_m++; end
        else if (dly >= 0 && dly < T)  exp_q.push_back({ehdr, eng_pay_cfg});
        else                           begin exp_q.push_back(err_resp(8'h04)); err_m++; end
        if (bpulse) begin exp_q.push_back(err_resp(8'h03)); err_m++; end
        acc_m++;
        ack_en = !hold; resp_seen = 0; eng_rise_cyc = -100; eng_high = 0;
        @(posedge clk); #1;
        t0 = cyc;
        r = rand_bits();
        bus.resp_req_in = 1; bus.auth_msg_resp_in = {h, r[PL-1:0]};
        @(posedge clk); #1;
        bus.resp_req_in = 0; bus.auth_msg_resp_in = rand_bits();
        if (bpulse) begin
            @(posedge clk); #1; bus.resp_req_in = 1;
            @(posedge clk); #1; bus.resp_req_in = 0;
        end
        if (hold) begin
            for (int i = 0; i < 40 && !bus.resp_req_out; i++) @(negedge clk);
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", bus.resp_req_out, 1'b1);
            end
            ack_en = 1;
        end
        wait_idle();
        if (code != 0) begin
            chk("err_latency", resp_rise_cyc - t0, 2);
            chk("err_no_eng", eng_high, 0);
        end else begin
            chk("eng_latency", eng_rise_cyc - t0, 2);
            if (dly >= 0 && dly < T) chk("ack_latency", resp_rise_cyc - ack_cyc, 1);
            else                     chk("timeout_len", eng_high, T);
        end
    endtask

    task automatic reset_mid_engine();
        exp_p1 = 8'h00; exp_p2 = 8'h00; exp_eng_type = 2'd3; eng_delay_cfg = -1;
        @(posedge clk); #1;
        bus.resp_req_in = 1; bus.auth_msg_resp_in = {32'h0183_0000, {PL{1'b0}}};
        @(posedge clk); #1;
        bus.resp_req_in = 0;
        for (int i = 0; i < 10 && !bus.eng_req; i++) @(negedge clk);
        chk("rst_eng_req_up", bus.eng_req, 1'b1);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); @(negedge clk);
        chk("rst_resp_req_out", bus.resp_req_out, 1'b0);
        chk("rst_msg_out", bus.auth_msg_resp_out, '0);
        chk("rst_eng_req", bus.eng_req, 1'b0);
        chk("rst_eng_type", bus.eng_type, '0);
        chk("rst_eng_p1", bus.eng_param1, '0);
        chk("rst_eng_p2", bus.eng_param2, '0);
        chk("rst_busy", bus.busy, 1'b0);
        exp_q.delete(); acc_m = 0; err_m = 0;
        reset = 1;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        bus.resp_req_in = 0; bus.auth_msg_resp_in = '0;
        reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_req_out", bus.resp_req_out, 1'b0);
        chk("reset_msg_out", bus.auth_msg_resp_out, '0);
        chk("reset_eng_req", bus.eng_req, 1'b0);
        chk("reset_eng_type", bus.eng_type, '0);
        chk("reset_busy", bus.busy, 1'b0);
        reset = 1;
        mon_en = 1;

        // GET_DIGESTS, engine acks 3 cycles in, response held until Ack_in
        do_req(32'h0181_0000, 3, 0, 1, 32'h0101_0000);
        chk("digests_hdr", last_resp[ML-1 -: 32], 32'h0101_0000);
        chk("digests_type", last_eng_type, 2'd1);
        // wrong protocol version
        do_req(32'h0281_0000, 3, 0, 0, 32'h0);
        chk("badver_hdr", last_resp[ML-1 -: 32], 32'h017F_0200);
        chk("badver_payload", last_resp[PL-1:0], '0);
        // slot range boundary
        do_req(32'h0182_0800, 3, 0, 0, 32'h0);
        chk("slot8_hdr", last_resp[ML-1 -: 32], 32'h017F_0100);
        do_req(32'h0182_0755, 2, 0, 0, 32'h0102_0700);
        chk("slot7_type", last_eng_type, 2'd2);
        chk("slot7_p1", last_eng_p1, 8'd7);
        // unknown message type
        do_req(32'h0184_0000, 0, 0, 0, 32'h0);
        chk("badtype_hdr", last_resp[ML-1 -: 32], 32'h017F_0100);
        // timeout boundary: ack in last allowed cycle wins, never-ack times out
        do_req(32'h0183_0102, T - 1, 0, 0, 32'h0103_0000);
        chk("late_ack_hdr", last_resp[ML-1 -: 32], 32'h0103_0000);
        do_req(32'h0183_0000, -1, 0, 0, 32'h0);
        chk("timeout_hdr", last_resp[ML-1 -: 32], 32'h017F_0400);
        // overlapping request during ENGINE -> one Busy response afterwards
        do_req(32'h0181_0000, 5, 1, 0, 32'h0101_0000);
        chk("busy_hdr", last_resp[ML-1 -: 32], 32'h017F_0300);
        // reset mid-ENGINE, then a normal request
        reset_mid_engine();
        do_req(32'h0181_0000, 1, 0, 0, 32'h0101_00AA);
        chk("post_reset_hdr", last_resp[ML-1 -: 32], 32'h0101_00AA);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] h;
            logic [7:0]  ty;
            h = $urandom;
            case ($urandom % 4)
                0: ty = 8'h81;
                1: ty = 8'h82;
                2: ty = 8'h83;
                default: ty = 8'($urandom);
            endcase
            h[23:16] = ty;
            if ($urandom % 6 != 0) h[31:24] = 8'h01;
            if (ty == 8'h82) h[15:8] = 8'($urandom % 12);
            do_req(h, int'($urandom % 20), ($urandom % 4 == 0), 0, $urandom);
        end

`ifdef RESP_STATS_EN
        chk("stat_req_cnt", stat_req_cnt, 16'(acc_m));
        chk("stat_err_cnt", stat_err_cnt, 16'(err_m));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
